serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes D = A − B − Bin one bit per clock, LSB first.
- Each bit cycle uses the full-subtractor equations, the inverse-direction counterpart of the combinational full adder.
- Intended for area-constrained datapaths. An upstream controller issues start pulses and consumes the registered results on a done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden).

Ports:
- i_Clk  input  1  system clock, rising-edge.
- i_Rst  input  1  reset, synchronous, active-high.
- i_Start  input  1  start request; sampled only in IDLE or DONE.
- i_A  input  WIDTH  minuend; captured on accepted start.
- i_B  input  WIDTH  subtrahend; captured on accepted start.
- i_Bin  input  1  borrow-in; captured on accepted start.
- o_Busy  output  1  high while in RUN.
- o_Done  output  1  single-cycle pulse when a result becomes valid.
- o_Diff  output  WIDTH  difference A − B − Bin, modulo 2^WIDTH.
- o_Bout  output  1  final borrow-out: 1 iff unsigned A < B + Bin.
- o_Ovf  output  1  signed overflow: (A[MSB]≠B[MSB]) & (Diff[MSB]≠A[MSB]).

Behaviour:
- Reset: one clock edge with i_Rst=1 forces state=IDLE, counter=0, all shift registers=0, borrow=0, o_Busy=0, o_Done=0, o_Diff=0, o_Bout=0, o_Ovf=0. i_Rst overrides all other inputs, including mid-RUN; the partial result is discarded and outputs read 0.
- States: IDLE, RUN, DONE.
- IDLE: on i_Start=1 at edge k:
  - load sa←i_A, sb←i_B, borrow←i_Bin, counter←0;
  - latch a_msb←i_A[WIDTH-1], b_msb←i_B[WIDTH-1];
  - state←RUN.
- RUN, every edge:
  - a=sa[0], b=sb[0];
  - d = a^b^borrow;
  - borrow ← (~a&b) | (~(a^b)&borrow);
  - shift d into the MSB of the result register (shift right); sa, sb shift right;
  - counter++.
- RUN exit: at the edge where counter reaches WIDTH (edge k+WIDTH):
  - o_Diff←completed result register, o_Bout←final borrow, o_Ovf←overflow per the port formula;
  - state←DONE.
- o_Busy=1 exactly in cycles k+1..k+WIDTH, i.e. WIDTH cycles.
- DONE: lasts one cycle, o_Done=1.
  - i_Start=1 here is accepted exactly as in IDLE (back-to-back): state→RUN, o_Done drops next cycle.
  - Otherwise → IDLE.
- Latency: o_Done is high in the cycle following edge k+WIDTH (WIDTH+1 cycles after start is sampled).
- Throughput: one operation per WIDTH+1 cycles.
- i_Start during RUN is ignored: no restart, operands unchanged.
- i_A, i_B and i_Bin may change freely after the accepting edge.
- o_Diff, o_Bout and o_Ovf hold their last result until the next DONE entry or reset. They never show partial values.
- Width rules: arithmetic is modulo 2^WIDTH; there are no extra result bits.

Test Plan (WIDTH=8):
- Normal subtraction: reset 2 cycles, then start A=0x05, B=0x03, Bin=0 → o_Busy high 8 cycles, o_Done pulse after 9 cycles; Diff=0x02, Bout=0, Ovf=0.
- Unsigned underflow: A=0x03, B=0x05, Bin=0 → Diff=0xFE, Bout=1, Ovf=0.
- Signed overflow: A=0x80, B=0x01, Bin=0 → Diff=0x7F, Bout=0, Ovf=1. Then A=0x7F, B=0xFF → Diff=0x80, Bout=1, Ovf=1.
- Borrow-in: A=0x00, B=0x00, Bin=1 → Diff=0xFF, Bout=1, Ovf=0.
- Start while busy, then back-to-back:
  - Start A=0x10, B=0x01; pulse i_Start with A=0xAA, B=0x00 at RUN cycle 3 → Diff=0x0F (second start ignored).
  - Holding i_Start=1 with A=0x20, B=0x10 during DONE → second o_Done exactly 9 cycles later, Diff=0x10.
- Reset mid-operation: start A=0x55, B=0x11, assert i_Rst in RUN cycle 4 → next cycle o_Busy=0, o_Done=0, o_Diff=0, state IDLE. A fresh start after reset produces the correct Diff=0x44.
- Randomised check: random A/B/Bin compared against the reference model A−B−Bin, for all three outputs.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Latency: o_Done pulses WIDTH+1 cycles after an accepted start; one operation per WIDTH+1 cycles.
// Backpressure: none; i_Start is taken only in IDLE or DONE and ignored while o_Busy is high.
//
// Ports:
//   i_Clk, i_Rst          rising-edge clock, synchronous active-high reset
//   i_Start, i_A, i_B,    start request and operands, captured on the accepting edge
//   i_Bin
//   o_Busy                high for the WIDTH cycles of bit-serial work
//   o_Done                one-cycle pulse when o_Diff/o_Bout/o_Ovf carry a fresh result
//   o_Diff, o_Bout, o_Ovf difference mod 2^WIDTH, final borrow, signed overflow (held until next result)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Bin,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Diff,
  output logic             o_Bout,
  output logic             o_Ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [WIDTH-1:0]   res;
  logic               borrow;
  logic               a_msb;
  logic               b_msb;

  // Full-subtractor slice on the current LSBs.
  logic               bit_a;
  logic               bit_b;
  logic               bit_d;
  logic               borrow_nxt;
  logic [WIDTH-1:0]   res_nxt;
  logic               last_bit;

  always_comb begin
    bit_a      = sa[0];
    bit_b      = sb[0];
    bit_d      = bit_a ^ bit_b ^ borrow;
    borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    // Result fills from the MSB end so after WIDTH shifts bit 0 sits at res[0].
    res_nxt    = {bit_d, res[WIDTH-1:1]};
    last_bit   = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      o_Busy <= 1'b0;
      o_Done <= 1'b0;
      o_Diff <= '0;
      o_Bout <= 1'b0;
      o_Ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_Done <= 1'b0;
          if (i_Start) begin
            sa     <= i_A;
            sb     <= i_B;
            borrow <= i_Bin;
            res    <= '0;
            cnt    <= '0;
            a_msb  <= i_A[WIDTH-1];
            b_msb  <= i_B[WIDTH-1];
            o_Busy <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= res_nxt;
          borrow <= borrow_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            // Publish only the completed word; outputs never see partial bits.
            o_Diff <= res_nxt;
            o_Bout <= borrow_nxt;
            o_Ovf  <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
            o_Busy <= 1'b0;
            o_Done <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          o_Busy <= 1'b0;
          o_Done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Start (start),
    .i_A     (a),
    .i_B     (b),
    .i_Bin   (bin),
    .o_Busy  (busy),
    .o_Done  (done),
    .o_Diff  (diff),
    .o_Bout  (bout),
    .o_Ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts negedges until o_Done is seen (bounded); also counts busy cycles.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat <= 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    int bc;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_v;
    bin = tbin;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    bin = 1'($urandom);
    wait_done(lat, bc);
    chk({name, "_latency"}, lat, 9);
    chk({name, "_busy_cycles"}, bc, 8);
    chk({name, "_diff"}, diff, ed);
    chk({name, "_bout"}, bout, eb);
    chk({name, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_diff_hold"}, diff, ed);
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    int bc;
    logic [8:0] wide;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf);
    end

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'hAA;
    b = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("busy_start_latency", lat, 6);
    chk("busy_start_diff", diff, 8'h0F);
    chk("busy_start_bout", bout, 0);
    chk("busy_start_ovf", ovf, 0);

    // Back-to-back: start accepted while in DONE.
    start = 1'b1;
    a = 8'h20;
    b = 8'h10;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    wait_done(lat, bc);
    chk("b2b_latency", lat, 9);
    chk("b2b_busy_cycles", bc, 8);
    chk("b2b_diff", diff, 8'h10);
    chk("b2b_bout", bout, 0);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    start = 1'b1;
    a = 8'h55;
    b = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    chk("midrst_ovf", ovf, 0);
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    run_op("after_rst", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);

    // Random operands against an independent wide-arithmetic model.
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      wide = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
      run_op($sformatf("rnd%0d", i), ra, rb, rbin, wide[7:0], wide[8],
             (ra[7] != rb[7]) && (wide[7] != ra[7]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
